// File: rtl/muxn_rr_reg.sv
// muxn_rr_reg: NCH-channel, WIDTH-bit selector with valid/ready handshakes and a
// single registered output slice. Mode 0 forwards the channel picked by sel; mode 1
// arbitrates round-robin among requesting channels.
// Optional macro MUXN_RR_LOCK_EN adds a lock input that pins the round-robin grant
// to the last granted channel while lock stays high.
module muxn_rr_reg #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
`ifdef MUXN_RR_LOCK_EN
  input  logic                 lock,
`endif
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_chan
);

  localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

  logic [WIDTH-1:0] w_ch_data [NCH];
  logic             w_sel_ok;
  logic [SELW:0]    w_rr;
  logic             w_has_grant;
  logic [SELW-1:0]  w_grant;
  logic             w_stage_ready;
  logic             w_xfer;
  logic             w_ptr_adv;
  logic [SELW-1:0]  w_ptr_nxt;

  logic [SELW-1:0]  r_ptr;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_chan;

`ifdef MUXN_RR_LOCK_EN
  logic             r_locked;
  logic [SELW-1:0]  r_lc;
`endif

  // First requesting channel at or after ptr, wrapping; MSB flags a hit.
  function automatic logic [SELW:0] rr_pick(input logic [NCH-1:0] valid,
                                            input logic [SELW-1:0] ptr);
    logic [SELW:0] res;
    int unsigned   k;
    res = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      k = 32'(ptr) + i;
      if (k >= NCH) k = k - NCH;
      if (!res[SELW] && valid[SELW'(k)]) res = {1'b1, SELW'(k)};
    end
    return res;
  endfunction

  // Unpack channel data for indexed selection.
  for (genvar c = 0; c < NCH; c++) begin : g_unpack
    assign w_ch_data[c] = in_data[c*WIDTH +: WIDTH];
  end

  // sel can only address a missing channel when NCH is not a power of two.
  if (NCH == (1 << SELW)) begin : g_sel_full
    assign w_sel_ok = 1'b1;
  end else begin : g_sel_part
    assign w_sel_ok = (32'(sel) < NCH);
  end

  // Grant selection for the current cycle.
  always_comb begin
    w_has_grant = 1'b0;
    w_grant     = '0;
    w_rr        = rr_pick(in_valid, r_ptr);
    if (!mode) begin
      if (w_sel_ok) begin
        w_has_grant = 1'b1;
        w_grant     = sel;
      end
    end
`ifdef MUXN_RR_LOCK_EN
    else if (r_locked && lock) begin
      w_has_grant = 1'b1;
      w_grant     = r_lc;
    end
`endif
    else begin
      w_has_grant = w_rr[SELW];
      w_grant     = w_rr[SELW-1:0];
    end
  end

  assign w_stage_ready = !r_out_valid || out_ready;
  assign w_xfer        = w_has_grant && w_stage_ready && in_valid[w_grant];
  assign w_ptr_nxt     = (w_grant == LAST_CH) ? '0 : w_grant + 1'b1;

`ifdef MUXN_RR_LOCK_EN
  assign w_ptr_adv = mode && w_xfer && !lock;
`else
  assign w_ptr_adv = mode && w_xfer;
`endif

  // One-hot ready toward the granted producer only.
  always_comb begin
    in_ready = '0;
    if (w_has_grant && w_stage_ready) in_ready[w_grant] = 1'b1;
  end

  // Output register slice: capture on transfer, drop valid once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_ch_data[w_grant];
      r_out_chan  <= w_grant;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Round-robin pointer moves past the winner on each unlocked mode-1 transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_ptr_adv) begin
      r_ptr <= w_ptr_nxt;
    end
  end

`ifdef MUXN_RR_LOCK_EN
  // Lock state: latch the winner of a locked transfer, drop on lock=0 or mode 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked <= 1'b0;
      r_lc     <= '0;
    end else if (!mode || !lock) begin
      r_locked <= 1'b0;
    end else if (w_xfer) begin
      r_locked <= 1'b1;
      r_lc     <= w_grant;
    end
  end
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;

endmodule
